// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter.
// Words enter a FIFO through a valid/ready handshake. Each word is sent
// LSB-first as: start bit, DATA_BITS data bits, optional parity bit,
// and STOP_BITS stop bits. Each bit lasts DIV = CLK_FREQ/BAUD_RATE clocks.
// Ports:
//   clk_i, rst_ni    clock, async active-low reset
//   tx_data_i/_vld_i write side of the FIFO; tx_data_rdy_o = !fifo_full_o
//   tx_o             registered serial line, idle high
//   tx_active_o      high while a frame is on the line
//   fifo_level_o     number of stored entries; fifo_full_o / fifo_empty_o flags
module uart_tx_fifo #(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD_RATE   = 19200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_TYPE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [DATA_BITS-1:0]          tx_data_i,
  input  logic                          tx_data_vld_i,
  output logic                          tx_data_rdy_o,
  output logic                          tx_o,
  output logic                          tx_active_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          fifo_full_o,
  output logic                          fifo_empty_o
);

  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW:0]   LVL_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // ---------------- FIFO ----------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          level_q;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  assign fifo_full_o   = (level_q == LVL_FULL);
  assign fifo_empty_o  = (level_q == '0);
  assign tx_data_rdy_o = ~fifo_full_o;
  assign fifo_level_o  = level_q;
  assign push          = tx_data_vld_i & ~fifo_full_o;
  assign head          = mem[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= tx_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  // ---------------- Serialiser ----------------
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 active_q;
  logic                 tick, head_par;

  assign tick     = (cnt_q == CNT_MAX);
  assign head_par = (PARITY_TYPE == 1) ? ~^head : ^head;

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + CNT_ONE;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!fifo_empty_o) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = head_par;
          state_d = START;
        end
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (tick) begin
        shift_d = shift_q >> 1;
        if (bit_q == DATA_LAST) begin
          state_d = (PARITY_TYPE != 0) ? PARITY : STOP;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end
      PARITY: if (tick) begin
        state_d = STOP;
        bit_d   = '0;
      end
      STOP: if (tick) begin
        if (bit_q != STOP_LAST) begin
          bit_d = bit_q + 4'd1;
        end else if (!fifo_empty_o) begin
          // chain straight into the next frame, no idle gap
          pop     = 1'b1;
          shift_d = head;
          par_d   = head_par;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // line value is a function of the next state so tx_o comes straight from a flop
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      active_q <= (state_d != IDLE);
    end
  end

  assign tx_o        = tx_q;
  assign tx_active_o = active_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: DIV=10 in every instance.
//   a: 8N1, FIFO_DEPTH=4     b: 8E2, depth 8     c: 8O1, depth 8
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] a_data, b_data, c_data;
  logic a_vld, a_rdy, a_tx, a_act, a_full, a_empty;
  logic b_vld, b_rdy, b_tx, b_act, b_full, b_empty;
  logic c_vld, c_rdy, c_tx, c_act, c_full, c_empty;
  logic [2:0] a_lvl;
  logic [3:0] b_lvl, c_lvl;

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                 .PARITY_TYPE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .tx_data_i(a_data), .tx_data_vld_i(a_vld),
    .tx_data_rdy_o(a_rdy), .tx_o(a_tx), .tx_active_o(a_act),
    .fifo_level_o(a_lvl), .fifo_full_o(a_full), .fifo_empty_o(a_empty));

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                 .PARITY_TYPE(2), .STOP_BITS(2), .FIFO_DEPTH(8)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .tx_data_i(b_data), .tx_data_vld_i(b_vld),
    .tx_data_rdy_o(b_rdy), .tx_o(b_tx), .tx_active_o(b_act),
    .fifo_level_o(b_lvl), .fifo_full_o(b_full), .fifo_empty_o(b_empty));

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                 .PARITY_TYPE(1), .STOP_BITS(1), .FIFO_DEPTH(8)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .tx_data_i(c_data), .tx_data_vld_i(c_vld),
    .tx_data_rdy_o(c_rdy), .tx_o(c_tx), .tx_active_o(c_act),
    .fifo_level_o(c_lvl), .fifo_full_o(c_full), .fifo_empty_o(c_empty));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decode one 8N1 frame from instance a, sampling mid-bit at negedges.
  // pre >= 0: start bit began pre negedges ago; pre < 0: wait for it.
  task automatic rx_a(input int pre, output logic [7:0] d);
    int n;
    int p;
    d = '0;
    p = pre;
    if (p < 0) begin
      n = 0;
      while (a_tx !== 1'b0 && n < 400) begin
        @(negedge clk);
        n++;
      end
      chk("rx_start_seen", a_tx, 1'b0);
      p = 0;
    end
    repeat (5 - p) @(negedge clk);
    chk("rx_start_mid", a_tx, 1'b0);
    for (int k = 0; k < 8; k++) begin
      repeat (10) @(negedge clk);
      d[k] = a_tx;
    end
    repeat (10) @(negedge clk);
    chk("rx_stop", a_tx, 1'b1);
  endtask

  logic [9:0]  f1, f;
  logic [11:0] fb;
  logic [10:0] fc;
  logic [7:0]  words [3];
  logic [7:0]  w4 [6];
  logic [7:0]  d;
  logic        acc;
  int          idx, acc_j;

  initial begin
    a_vld = 0; b_vld = 0; c_vld = 0;
    a_data = 0; b_data = 0; c_data = 0;
    repeat (3) @(negedge clk);
    chk("rst_tx", a_tx, 1);
    chk("rst_act", a_act, 0);
    chk("rst_lvl", a_lvl, 0);
    chk("rst_empty", a_empty, 1);
    chk("rst_full", a_full, 0);
    chk("rst_rdy", a_rdy, 1);
    chk("rst_b_tx", b_tx, 1);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // ---- 1: single 0xA5 frame, 8N1 ----
    a_data = 8'hA5; a_vld = 1;
    @(negedge clk);
    a_vld = 0; a_data = 8'h3C;
    chk("t1_lvl_after_push", a_lvl, 1);
    chk("t1_tx_still_idle", a_tx, 1);
    f1 = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("t1_tx", a_tx, f1[i/10]);
      chk("t1_act", a_act, 1);
    end
    @(negedge clk);
    chk("t1_act_end", a_act, 0);
    chk("t1_tx_end", a_tx, 1);
    chk("t1_lvl_end", a_lvl, 0);

    // ---- 2: three back-to-back words ----
    words[0] = 8'h55; words[1] = 8'h0F; words[2] = 8'hFF;
    a_data = words[0]; a_vld = 1;
    @(negedge clk);
    chk("t2_lvl0", a_lvl, 1);
    a_data = words[1];
    @(negedge clk);
    chk("t2_lvl1", a_lvl, 1);
    chk("t2_start", a_tx, 0);
    a_data = words[2];
    @(negedge clk);
    chk("t2_lvl2", a_lvl, 2);
    chk("t2_rdy", a_rdy, 1);
    a_vld = 0;
    for (int i = 1; i < 300; i++) begin
      if (i > 1) @(negedge clk);
      f = {1'b1, words[i/100], 1'b0};
      chk("t2_tx", a_tx, f[(i%100)/10]);
      chk("t2_act", a_act, 1);
      if (i == 150) chk("t2_lvl_mid", a_lvl, 1);
      if (i == 250) chk("t2_lvl_late", a_lvl, 0);
    end
    @(negedge clk);
    chk("t2_act_end", a_act, 0);
    chk("t2_lvl_end", a_lvl, 0);

    // ---- 3: parity (b even + 2 stop, c odd + 1 stop), data 0x07 ----
    fb = {1'b1, 1'b1, 1'b1, 8'h07, 1'b0};
    fc = {1'b1, 1'b0, 8'h07, 1'b0};
    b_data = 8'h07; c_data = 8'h07; b_vld = 1; c_vld = 1;
    @(negedge clk);
    b_vld = 0; c_vld = 0;
    for (int i = 0; i <= 120; i++) begin
      @(negedge clk);
      if (i < 120) begin
        chk("t3_b_tx", b_tx, fb[i/10]);
        chk("t3_b_act", b_act, 1);
      end else begin
        chk("t3_b_tx_idle", b_tx, 1);
        chk("t3_b_act_end", b_act, 0);
      end
      if (i < 110) begin
        chk("t3_c_tx", c_tx, fc[i/10]);
        chk("t3_c_act", c_act, 1);
      end else begin
        chk("t3_c_tx_idle", c_tx, 1);
        chk("t3_c_act_end", c_act, 0);
      end
    end

    // ---- 4 + 6: fill depth-4 FIFO with vld held; junk data while stalled ----
    w4[0] = 8'h11; w4[1] = 8'hC3; w4[2] = 8'h5A;
    w4[3] = 8'h96; w4[4] = 8'hE7; w4[5] = 8'h3D;
    idx = 0; acc_j = -1;
    a_data = w4[0]; a_vld = 1;
    for (int j = 0; j < 300 && idx < 6; j++) begin
      acc = a_rdy;
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx == 6) acc_j = j;
      end
      if (j == 4) begin
        chk("t4_full", a_full, 1);
        chk("t4_rdy_low", a_rdy, 0);
        chk("t4_lvl_full", a_lvl, 4);
      end
      if (j == 60)  chk("t6_stall_lvl", a_lvl, 4);
      if (j == 100) chk("t4_rdy_before_pop", a_rdy, 0);
      if (j == 101) begin
        chk("t4_rdy_after_pop", a_rdy, 1);
        chk("t4_lvl_after_pop", a_lvl, 3);
      end
      if (idx < 6) a_data = a_rdy ? w4[idx] : 8'($urandom);
      else a_vld = 0;
    end
    a_vld = 0;
    chk("t4_accept_edge", acc_j, 102);
    chk("t4_lvl_refill", a_lvl, 4);
    rx_a(1, d);
    chk("t4_order1", d, w4[1]);
    for (int k = 2; k < 6; k++) begin
      rx_a(-1, d);
      chk("t4_order", d, w4[k]);
    end
    repeat (10) @(negedge clk);
    chk("t4_drained_act", a_act, 0);
    chk("t4_drained_empty", a_empty, 1);

    // ---- 5: reset during data bit 3 with two words queued ----
    a_data = 8'h81; a_vld = 1;
    @(negedge clk);
    a_data = 8'h42;
    @(negedge clk);
    a_data = 8'h24;
    @(negedge clk);
    a_vld = 0;
    repeat (44) @(negedge clk);
    chk("t5_pre_lvl", a_lvl, 2);
    chk("t5_pre_act", a_act, 1);
    rst_n = 0;
    #1;
    chk("t5_rst_tx", a_tx, 1);
    chk("t5_rst_act", a_act, 0);
    chk("t5_rst_lvl", a_lvl, 0);
    chk("t5_rst_empty", a_empty, 1);
    chk("t5_rst_rdy", a_rdy, 1);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("t5_idle_tx", a_tx, 1);
      chk("t5_idle_act", a_act, 0);
    end
    a_data = 8'h99; a_vld = 1;
    @(negedge clk);
    a_vld = 0;
    rx_a(-1, d);
    chk("t5_after_rst_word", d, 8'h99);
    repeat (10) @(negedge clk);
    chk("t5_final_act", a_act, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
